// File: rtl/executor_pkg.sv
// rtl/executor_pkg.sv - op codes, FSM states and op-class helpers for param_executor
package executor_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LDI  = 4'd1;
  localparam logic [3:0] OP_MOV  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_A, S_FETCH_B, S_EXEC, S_WRITE, S_DONE, S_ERR
  } state_e;

  // Destination register is an operand: every arithmetic/logic op.
  function automatic logic needs_read_a(input logic [3:0] op);
    return (op >= OP_ADDI) && (op <= OP_XOR);
  endfunction

  // Source register comes from the data field.
  function automatic logic needs_read_b(input logic [3:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

  function automatic logic is_legal(input logic [3:0] op, input logic addr_ok,
                                    input logic src_ok);
    return (op >= OP_LDI) && (op <= OP_XOR) && addr_ok && (!needs_read_b(op) || src_ok);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational ALU for param_executor
// EXECUTOR_SAT_EN: saturate ADD/SUB results instead of wrapping.
module exec_alu
  import executor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADDI, OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
`ifdef EXECUTOR_SAT_EN
        if (sum[DATA_W]) result = '1;
`endif
      end
      OP_SUBI, OP_SUB: begin
        // Extended MSB of the difference is the borrow (a < b).
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
`ifdef EXECUTOR_SAT_EN
        if (diff[DATA_W]) result = '0;
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/param_executor.sv
// rtl/param_executor.sv - read-modify-write instruction executor on an external register memory
// EXECUTOR_SAT_EN (in exec_alu) selects saturating ADD/SUB.
module param_executor
  import executor_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic                       Clock,
  input  logic                       ResetN,
  input  logic [4+ADDR_W+DATA_W-1:0] OpCode,
  output logic                       MemEn,
  output logic                       MemRW,
  output logic [ADDR_W-1:0]          MemSelect,
  output logic [DATA_W-1:0]          MemWrData,
  input  logic [DATA_W-1:0]          MemRdData,
  output logic                       Done,
  output logic                       Carry,
  output logic                       Zero,
  output logic                       Error
);

  localparam logic [ADDR_W:0] NREG_L = (ADDR_W+1)'(NREG);

  state_e state, state_d;

  logic [3:0]        op_in, op_q;
  logic [ADDR_W-1:0] addr_in, addr_q, src_in, src_q, sel_q;
  logic [DATA_W-1:0] data_in, data_q, a_q, res_q, wdata_q;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              alu_carry, alu_zero, carry_q, zero_q;
  logic              addr_ok, src_ok, accept;

  assign op_in   = OpCode[4+ADDR_W+DATA_W-1 -: 4];
  assign addr_in = OpCode[DATA_W +: ADDR_W];
  assign data_in = OpCode[DATA_W-1:0];

  // Source register index: low data bits, zero-extended when the data field is narrower.
  generate
    if (DATA_W >= ADDR_W) begin : g_src_trunc
      assign src_in = data_in[ADDR_W-1:0];
    end else begin : g_src_ext
      assign src_in = {{(ADDR_W-DATA_W){1'b0}}, data_in};
    end
  endgenerate

  assign addr_ok = {1'b0, addr_in} < NREG_L;
  assign src_ok  = {1'b0, src_in} < NREG_L;
  assign accept  = (state == S_IDLE) && (OpCode != '0);

  // Register ops read A in FETCH_A (captured in FETCH_B), B arrives in EXEC.
  assign alu_a = needs_read_b(op_q) ? a_q : MemRdData;
  assign alu_b = needs_read_b(op_q) ? MemRdData : data_q;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d   = state;
    MemEn     = 1'b0;
    MemRW     = 1'b0;
    MemSelect = sel_q;
    MemWrData = wdata_q;
    Done      = 1'b0;
    Error     = 1'b0;
    case (state)
      S_IDLE: begin
        if (OpCode != '0) begin
          if (!is_legal(op_in, addr_ok, src_ok)) state_d = S_ERR;
          else if (op_in == OP_LDI)              state_d = S_WRITE;
          else if (needs_read_a(op_in))          state_d = S_FETCH_A;
          else                                   state_d = S_FETCH_B;
        end
      end
      S_FETCH_A: begin
        MemEn     = 1'b1;
        MemSelect = addr_q;
        state_d   = needs_read_b(op_q) ? S_FETCH_B : S_EXEC;
      end
      S_FETCH_B: begin
        MemEn     = 1'b1;
        MemSelect = src_q;
        state_d   = S_EXEC;
      end
      S_EXEC: state_d = S_WRITE;
      S_WRITE: begin
        MemEn     = 1'b1;
        MemRW     = 1'b1;
        MemSelect = addr_q;
        MemWrData = res_q;
        state_d   = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (OpCode == '0) state_d = S_IDLE;
      end
      S_ERR: begin
        Done  = 1'b1;
        Error = 1'b1;
        if (OpCode == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Carry = carry_q;
  assign Zero  = zero_q;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state   <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      data_q  <= '0;
      a_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      sel_q   <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_d;
      sel_q   <= MemSelect;
      wdata_q <= MemWrData;
      if (accept) begin
        op_q   <= op_in;
        addr_q <= addr_in;
        src_q  <= src_in;
        data_q <= data_in;
        res_q  <= data_in;
      end
      if (state == S_FETCH_B && needs_read_a(op_q)) a_q <= MemRdData;
      if (state == S_EXEC) begin
        res_q <= alu_res;
        if (needs_read_a(op_q)) begin
          carry_q <= alu_carry;
          zero_q  <= alu_zero;
        end
      end
    end
  end

endmodule

// File: tb/tb_param_executor.sv
// tb/tb_param_executor.sv - directed and random bench for param_executor with a register memory model
module tb_param_executor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] opcode = '0;
  logic        mem_en, mem_rw, done, carry, zero, error;
  logic [7:0]  mem_sel, mem_wdata;
  logic [7:0]  mem_rdata = '0;

`ifdef EXECUTOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  int wr_count = 0;
  int en_count = 0;
  int last_wsel = 0;
  int last_wdata = 0;

  int ref_regs [4];
  bit ref_carry = 1'b0;
  bit ref_zero = 1'b0;

  param_executor #(.DATA_W(8), .ADDR_W(8), .NREG(4)) dut (
    .Clock     (clk),
    .ResetN    (rst_n),
    .OpCode    (opcode),
    .MemEn     (mem_en),
    .MemRW     (mem_rw),
    .MemSelect (mem_sel),
    .MemWrData (mem_wdata),
    .MemRdData (mem_rdata),
    .Done      (done),
    .Carry     (carry),
    .Zero      (zero),
    .Error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) en_count++;
    if (mem_en && !mem_rw) mem_rdata <= mem[mem_sel];
    if (mem_en && mem_rw) begin
      mem[mem_sel] = mem_wdata;
      wr_count++;
      last_wsel  = mem_sel;
      last_wdata = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one instruction, predict it from the op table, check latency, write, flags, hold and release.
  task automatic run(input int op, input int addr, input int data, input int hold);
    bit legal, regsrc, c;
    int a, b, r, exp_lat, lat, wr0, en0;
    regsrc = (op == 2) || (op == 4) || (op == 6) || (op == 7) || (op == 8) || (op == 9);
    legal  = (op >= 1) && (op <= 9) && (addr < 4) && (!regsrc || data < 4);
    c = 1'b0;
    r = 0;
    if (legal) begin
      a = ref_regs[addr];
      b = regsrc ? ref_regs[data] : data;
      case (op)
        1: r = data;
        2: r = b;
        3, 4: begin
          r = a + b;
          c = (r > 255);
          r = r % 256;
          if (SAT && c) r = 255;
        end
        5, 6: begin
          c = (a < b);
          r = (a - b + 256) % 256;
          if (SAT && c) r = 0;
        end
        7: r = a & b;
        8: r = a | b;
        default: r = a ^ b;
      endcase
      if (op >= 3) begin
        ref_carry = c;
        ref_zero  = (r == 0);
      end
      ref_regs[addr] = r;
    end
    if (!legal)                     exp_lat = 1;
    else if (op == 1)               exp_lat = 2;
    else if (op == 2)               exp_lat = 4;
    else if (op == 3 || op == 5)    exp_lat = 4;
    else                            exp_lat = 5;

    @(negedge clk);
    wr0 = wr_count;
    en0 = en_count;
    opcode = {op[3:0], addr[7:0], data[7:0]};
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      lat++;
      @(negedge clk);
      if (done) break;
      @(posedge clk);
    end
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check($sformatf("error op%0d", op), error, !legal);
    check($sformatf("writes op%0d", op), wr_count - wr0, legal ? 1 : 0);
    if (legal) begin
      check($sformatf("wsel op%0d", op), last_wsel, addr);
      check($sformatf("wdata op%0d", op), last_wdata, r);
    end else begin
      check("err_no_memen", en_count - en0, 0);
    end
    check($sformatf("carry op%0d", op), carry, ref_carry);
    check($sformatf("zero op%0d", op), zero, ref_zero);
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      check("hold_no_rerun", wr_count - wr0, legal ? 1 : 0);
      check("hold_done", done, 1);
    end
    opcode = '0;
    @(negedge clk);
    check("done_fall", done, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) ref_regs[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_memen", mem_en, 0);
    check("rst_done", done, 0);
    check("rst_flags", {carry, zero, error}, 0);
    check("rst_sel", mem_sel, 0);
    check("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;

    run(1, 2, 8'hAA, 2);
    check("ldi_r2", last_wdata, 8'hAA);
    run(1, 1, 74, 0);
    run(2, 1, 2, 0);
    run(3, 1, 1, 0);
    run(3, 1, 1, 0);
    check("r1_final", last_wdata, 8'hAC);
    run(1, 0, 0, 0);
    run(3, 0, 7, 0);
    run(3, 0, 7, 0);
    check("r0_14", last_wdata, 14);
    run(5, 0, 3, 0);
    run(5, 0, 1, 0);
    check("r0_10", last_wdata, 10);
    run(1, 3, 8'h0A, 0);
    run(6, 0, 3, 0);
    check("sub_zero", {last_wdata[7:0], zero}, {8'h00, 1'b1});
    run(1, 0, 8'hFF, 0);
    run(3, 0, 1, 0);
`ifdef EXECUTOR_SAT_EN
    check("wrap_add", {last_wdata[7:0], carry, zero}, {8'hFF, 1'b1, 1'b0});
`else
    check("wrap_add", {last_wdata[7:0], carry, zero}, {8'h00, 1'b1, 1'b1});
`endif
    run(1, 0, 0, 0);
    run(5, 0, 1, 0);
`ifdef EXECUTOR_SAT_EN
    check("wrap_sub", {last_wdata[7:0], carry}, {8'h00, 1'b1});
`else
    check("wrap_sub", {last_wdata[7:0], carry}, {8'hFF, 1'b1});
`endif
    run(12, 0, 0, 10);
    run(1, 5, 8'h11, 10);
    run(4, 1, 7, 2);

    // Reset asserted while an ADD sits in FETCH_B.
    @(negedge clk);
    begin
      int wr0;
      wr0 = wr_count;
      opcode = {4'd4, 8'd0, 8'd1};
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", {mem_en, mem_rw, done, carry, zero, error}, 0);
      check("mid_rst_bus", {mem_sel, mem_wdata}, 0);
      opcode = '0;
      repeat (3) @(negedge clk);
      check("mid_rst_no_write", wr_count - wr0, 0);
      rst_n = 1'b1;
      ref_carry = 1'b0;
      ref_zero  = 1'b0;
    end
    run(4, 0, 1, 0);

    for (int n = 0; n < 80; n++) begin
      int op, addr, data;
      op   = $urandom_range(1, 15);
      addr = $urandom_range(0, 5);
      data = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 4);
      run(op, addr, data, $urandom_range(0, 2));
    end

    for (int i = 0; i < 4; i++) check($sformatf("mem_r%0d", i), mem[i], ref_regs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
